uart_tx_arbiter: RTL and testbench

- Shares one `uart_tx` transmitter between NUM_REQ byte-stream requesters.
- Arbitration is round-robin with frame locking. A requester that wins keeps the transmitter until it sends a byte marked last.
- Drives the transmitter's `Tx_dv`/`Tx_Byte` inputs and sequences from its `o_Tx_Active`/`o_Tx_Done` flags.
- Sits between the protocol/command layers and the single `uart_tx` instance.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
// The arbiter state type and a wrap-around index helper live here.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACT,
    WAIT_DONE,
    WAIT_IDLE
  } arb_state_t;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request at or
// after i_ptr, wrapping around. Kept generic so an RX dispatcher can reuse it.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int w_j;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[IW'(w_j)]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with frame locking in front of a single uart_tx.
// Handshake: a byte moves when req_valid[i] and req_ready[i] are both high in one cycle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_dv,
  output logic [UART_BYTE_W-1:0]         tx_byte,
  input  logic                           tx_active,
  input  logic                           tx_done,
  output logic [ID_W-1:0]                grant_id,
  output logic                           locked,
  output logic                           byte_sent,
  output logic                           lock_err
);

  localparam logic [7:0] LOCK_MAX = 8'(LOCK_TIMEOUT - 1);

  arb_state_t             r_state, w_state_next;
  logic [ID_W-1:0]        r_ptr, r_grant_id;
  logic [ID_W-1:0]        w_pick_idx, w_win;
  logic                   r_locked, r_tx_dv, r_byte_sent, r_lock_err;
  logic [UART_BYTE_W-1:0] r_tx_byte, w_win_data;
  logic [7:0]             r_lock_cnt;
  logic                   w_pick_found, w_win_valid, w_win_last;
  logic                   w_accept, w_lock_idle, w_timeout;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // While a frame is open only the owner is a candidate.
  always_comb begin
    w_win       = r_locked ? r_grant_id : w_pick_idx;
    w_win_valid = r_locked ? req_valid[r_grant_id] : w_pick_found;
    w_win_data  = '0;
    w_win_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        w_win_last = req_last[i];
      end
    end
    // Transmitter must be fully back in its wait state before a new tx_dv.
    w_accept    = rst_n && (r_state == IDLE) && w_win_valid && !tx_active && !tx_done;
    w_lock_idle = (r_state == IDLE) && r_locked && !req_valid[r_grant_id];
    w_timeout   = w_lock_idle && (r_lock_cnt == LOCK_MAX);
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_accept && (w_win == ID_W'(i));
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_accept)   w_state_next = WAIT_ACT;
      WAIT_ACT:  if (tx_active)  w_state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done)    w_state_next = WAIT_IDLE;
      WAIT_IDLE: if (!tx_done)   w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
      r_grant_id  <= '0;
      r_locked    <= 1'b0;
      r_byte_sent <= 1'b0;
      r_lock_err  <= 1'b0;
      r_ptr       <= '0;
      r_lock_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tx_dv     <= w_accept;
      r_byte_sent <= (r_state == WAIT_DONE) && tx_done;
      r_lock_err  <= w_timeout;
      if (w_accept) begin
        r_tx_byte  <= w_win_data;
        r_grant_id <= w_win;
        r_locked   <= ~w_win_last;
        r_lock_cnt <= '0;
        if (w_win_last) r_ptr <= ID_W'(wrap_inc(int'(w_win), NUM_REQ));
      end else if (w_timeout) begin
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
        r_ptr      <= ID_W'(wrap_inc(int'(r_grant_id), NUM_REQ));
      end else if (w_lock_idle) begin
        r_lock_cnt <= r_lock_cnt + 8'd1;
      end
    end
  end

  assign tx_dv     = r_tx_dv;
  assign tx_byte   = r_tx_byte;
  assign grant_id  = r_grant_id;
  assign locked    = r_locked;
  assign byte_sent = r_byte_sent;
  assign lock_err  = r_lock_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx (CLK_PER_BIT=4) drives the
// serial line, which is decoded and matched against bytes the bench expects.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;
  localparam int OCC = 10 * CPB + 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        locked, byte_sent, lock_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bs_cycles = 0;
  int bad_dv = 0;
  int frames_seen = 0;
  logic [9:0] last_frame = '0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
    .locked(locked), .byte_sent(byte_sent), .lock_err(lock_err)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural uart_tx (no reset) ----------------
  int         m_state = 0;  // 0 idle,1 start,2 data,3 stop,4 cleanup
  int         m_cnt = 0;
  int         m_bit = 0;
  logic [7:0] m_sh = '0;
  logic       tx_serial = 1'b1;

  always @(posedge clk) begin
    case (m_state)
      0: begin
        tx_serial <= 1'b1; tx_done <= 1'b0; m_cnt <= 0; m_bit <= 0;
        if (tx_dv) begin tx_active <= 1'b1; m_sh <= tx_byte; m_state <= 1; end
      end
      1: begin
        tx_serial <= 1'b0;
        if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
        else begin m_cnt <= 0; m_state <= 2; end
      end
      2: begin
        tx_serial <= m_sh[m_bit];
        if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
        else begin
          m_cnt <= 0;
          if (m_bit < 7) m_bit <= m_bit + 1;
          else begin m_bit <= 0; m_state <= 3; end
        end
      end
      3: begin
        tx_serial <= 1'b1;
        if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
        else begin m_cnt <= 0; tx_done <= 1'b1; tx_active <= 1'b0; m_state <= 4; end
      end
      default: begin tx_done <= 1'b1; m_state <= 0; end
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  always @(negedge clk) begin
    if (byte_sent) bs_cycles++;
    if (tx_dv && (tx_active || tx_done)) bad_dv++;
  end

  // Serial decoder / scoreboard: samples each bit near its middle.
  initial begin
    logic [9:0] fr;
    forever begin
      @(negedge tx_serial);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        fr[i] = tx_serial;
        if (i < 9) repeat (CPB) @(negedge clk);
      end
      frames_seen++;
      last_frame = fr;
      check("frame_framing", {30'd0, fr[9], fr[0]}, 32'd2);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_unexpected: got %0h expected none", fr[8:1]);
      end else begin
        check("frame_byte", {24'd0, fr[8:1]}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [7:0] d, input logic l);
    req_data[id*8 +: 8] = d;
    req_last[id]        = l;
    req_valid[id]       = 1'b1;
  endtask

  task automatic drop_req(input int id);
    req_valid[id] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic settle();
    repeat (60) @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, output logic [3:0] rdy, output int at);
    rdy = '0; at = -1;
    #1;
    for (int n = 0; n < 300; n++) begin
      if (req_ready != 4'd0) begin rdy = req_ready; at = cyc; return; end
      @(negedge clk); #1;
    end
    fail_timeout(name);
  endtask

  task automatic wait_frames(input int target);
    for (int n = 0; n < 500; n++) begin
      if (frames_seen >= target) return;
      @(negedge clk);
    end
    fail_timeout("wait_frames");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [7:0] exp_byte;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] rdy;
    int at, f0, bs0, le_cyc, le_cnt, rdy_cyc;
    int t[4];
    logic rdy_locked;
    logic [3:0] rdy_seen;
    logic [7:0] cb[3];
    int cid[3];

    // requester i drives 8'hC0|i; all single-byte frames
    vecs[0] = '{4'b1010, 4'b0010, 8'hC1, 2'd1};
    vecs[1] = '{4'b0011, 4'b0001, 8'hC0, 2'd0};
    vecs[2] = '{4'b1111, 4'b0010, 8'hC1, 2'd1};
    vecs[3] = '{4'b1000, 4'b1000, 8'hC3, 2'd3};
    vecs[4] = '{4'b1001, 4'b0001, 8'hC0, 2'd0};
    vecs[5] = '{4'b0001, 4'b0001, 8'hC0, 2'd0};
    vecs[6] = '{4'b0101, 4'b0100, 8'hC2, 2'd2};
    vecs[7] = '{4'b0111, 4'b0001, 8'hC0, 2'd0};

    // ---- reset values ----
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_tx_dv", {31'd0, tx_dv}, 0);
    check("rst_tx_byte", {24'd0, tx_byte}, 0);
    check("rst_grant", {30'd0, grant_id}, 0);
    check("rst_flags", {29'd0, locked, byte_sent, lock_err}, 0);
    check("rst_ready", {28'd0, req_ready}, 0);

    // ---- table: rotating priority from pointer 0 ----
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        req_data[i*8 +: 8] = 8'hC0 | 8'(i);
        req_last[i] = 1'b1;
      end
      req_valid = vecs[v].valid;
      wait_ready("tbl_wait", rdy, at);
      check("tbl_ready", {28'd0, rdy}, {28'd0, vecs[v].exp_ready});
      exp_q.push_back(vecs[v].exp_byte);
      @(negedge clk); #1;
      req_valid = '0;
      check("tbl_tx_dv", {31'd0, tx_dv}, 1);
      check("tbl_tx_byte", {24'd0, tx_byte}, {24'd0, vecs[v].exp_byte});
      check("tbl_grant", {30'd0, grant_id}, {30'd0, vecs[v].exp_grant});
    end
    settle();

    // ---- single byte A5 from req0 ----
    do_reset();
    f0 = frames_seen; bs0 = bs_cycles;
    set_req(0, 8'hA5, 1'b1);
    wait_ready("a5_wait", rdy, at);
    check("a5_ready", {28'd0, rdy}, 32'b0001);
    exp_q.push_back(8'hA5);
    @(negedge clk); #1;
    drop_req(0);
    check("a5_ready_one_cycle", {28'd0, req_ready}, 0);
    check("a5_tx_dv", {31'd0, tx_dv}, 1);
    check("a5_tx_byte", {24'd0, tx_byte}, 32'hA5);
    @(negedge clk); #1;
    check("a5_tx_dv_pulse", {31'd0, tx_dv}, 0);
    wait_frames(f0 + 1);
    check("a5_serial_bits", {22'd0, last_frame}, {22'd0, 1'b1, 8'hA5, 1'b0});
    repeat (10) @(negedge clk);
    check("a5_byte_sent_cycles", bs_cycles - bs0, 1);
    // pointer now 1: req1 beats req0
    set_req(0, 8'h0F, 1'b1);
    set_req(1, 8'hF1, 1'b1);
    wait_ready("ptr1_wait", rdy, at);
    check("ptr1_ready", {28'd0, rdy}, 32'b0010);
    exp_q.push_back(8'hF1);
    @(negedge clk); #1;
    drop_req(1);
    wait_ready("ptr1b_wait", rdy, at);
    check("ptr1b_ready", {28'd0, rdy}, 32'b0001);
    exp_q.push_back(8'h0F);
    @(negedge clk); #1;
    drop_req(0);
    settle();

    // ---- contention: req0, req1, req3 ----
    do_reset();
    cb[0] = 8'h11; cb[1] = 8'h22; cb[2] = 8'h44;
    cid[0] = 0; cid[1] = 1; cid[2] = 3;
    set_req(0, 8'h11, 1'b1);
    set_req(1, 8'h22, 1'b1);
    set_req(3, 8'h44, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_ready("cont_wait", rdy, at);
      check("cont_ready", {28'd0, rdy}, 32'(1) << cid[k]);
      exp_q.push_back(cb[k]);
      @(negedge clk); #1;
      drop_req(cid[k]);
      check("cont_tx_byte", {24'd0, tx_byte}, {24'd0, cb[k]});
    end
    settle();
    check("cont_idle_ready", {28'd0, req_ready}, 0);
    // pointer back to 0: req0 beats req3
    set_req(0, 8'h5C, 1'b1);
    set_req(3, 8'hC5, 1'b1);
    wait_ready("ptr0_wait", rdy, at);
    check("ptr0_ready", {28'd0, rdy}, 32'b0001);
    exp_q.push_back(8'h5C);
    @(negedge clk); #1;
    drop_req(0);
    wait_ready("ptr0b_wait", rdy, at);
    check("ptr0b_ready", {28'd0, rdy}, 32'b1000);
    exp_q.push_back(8'hC5);
    @(negedge clk); #1;
    drop_req(3);
    settle();

    // ---- lock: req2 3-byte frame while req1 valid ----
    do_reset();
    set_req(2, 8'h01, 1'b0);
    wait_ready("lock_w1", rdy, at);
    check("lock_r1", {28'd0, rdy}, 32'b0100);
    exp_q.push_back(8'h01);
    @(negedge clk); #1;
    set_req(2, 8'h02, 1'b0);
    set_req(1, 8'h55, 1'b1);
    check("lock_locked1", {31'd0, locked}, 1);
    wait_ready("lock_w2", rdy, at);
    check("lock_r2", {28'd0, rdy}, 32'b0100);
    exp_q.push_back(8'h02);
    @(negedge clk); #1;
    set_req(2, 8'h03, 1'b1);
    check("lock_locked2", {31'd0, locked}, 1);
    wait_ready("lock_w3", rdy, at);
    check("lock_r3", {28'd0, rdy}, 32'b0100);
    check("lock_locked3_pre", {31'd0, locked}, 1);
    exp_q.push_back(8'h03);
    @(negedge clk); #1;
    drop_req(2);
    check("lock_released", {31'd0, locked}, 0);
    check("lock_tx_byte3", {24'd0, tx_byte}, 32'h03);
    wait_ready("lock_w4", rdy, at);
    check("lock_r4", {28'd0, rdy}, 32'b0010);
    exp_q.push_back(8'h55);
    @(negedge clk); #1;
    drop_req(1);
    settle();

    // ---- lock timeout ----
    do_reset();
    set_req(1, 8'hF0, 1'b0);
    wait_ready("to_wait", rdy, at);
    check("to_ready", {28'd0, rdy}, 32'b0010);
    exp_q.push_back(8'hF0);
    @(negedge clk); #1;
    drop_req(1);
    set_req(0, 8'h3C, 1'b1);
    check("to_locked", {31'd0, locked}, 1);
    le_cyc = -1; le_cnt = 0; rdy_cyc = -1; rdy_seen = '0; rdy_locked = 1'b1;
    for (int n = 2; n < 120; n++) begin
      @(negedge clk); #1;
      if (lock_err) begin
        le_cnt++;
        if (le_cyc < 0) le_cyc = n;
      end
      if (req_ready != 4'd0) begin
        rdy_cyc = n; rdy_seen = req_ready; rdy_locked = locked;
        break;
      end
    end
    // IDLE re-entry is OCC cycles after accept; timeout fires 8 IDLE cycles later
    check("to_lock_err_cycle", le_cyc, OCC + 8);
    check("to_req0_cycle", rdy_cyc, OCC + 8);
    check("to_req0_ready", {28'd0, rdy_seen}, 32'b0001);
    check("to_unlocked", {31'd0, rdy_locked}, 0);
    exp_q.push_back(8'h3C);
    @(negedge clk); #1;
    drop_req(0);
    check("to_lock_err_pulse", {31'd0, lock_err}, 0);
    check("to_lock_err_count", le_cnt, 1);
    check("to_tx_byte", {24'd0, tx_byte}, 32'h3C);
    settle();

    // ---- reset in the middle of a byte ----
    do_reset();
    set_req(2, 8'h96, 1'b0);
    wait_ready("mr_wait", rdy, at);
    check("mr_ready", {28'd0, rdy}, 32'b0100);
    exp_q.push_back(8'h96);
    @(negedge clk); #1;
    drop_req(2);
    check("mr_pre_locked", {31'd0, locked}, 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    set_req(1, 8'h5A, 1'b1);
    #1;
    check("mr_ready_in_reset", {28'd0, req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_tx_dv", {31'd0, tx_dv}, 0);
    check("mr_tx_byte", {24'd0, tx_byte}, 0);
    check("mr_grant", {30'd0, grant_id}, 0);
    check("mr_flags", {29'd0, locked, byte_sent, lock_err}, 0);
    check("mr_ready_busy", {28'd0, req_ready}, 0);
    wait_ready("mr_w2", rdy, at);
    check("mr_r2", {28'd0, rdy}, 32'b0010);
    check("mr_tx_quiet_at_accept", {30'd0, tx_active, tx_done}, 0);
    exp_q.push_back(8'h5A);
    @(negedge clk); #1;
    drop_req(1);
    check("mr_tx_byte2", {24'd0, tx_byte}, 32'h5A);
    settle();

    // ---- back-to-back single requester ----
    do_reset();
    set_req(3, 8'hD0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      wait_ready("b2b_wait", rdy, at);
      check("b2b_ready", {28'd0, rdy}, 32'b1000);
      t[b] = at;
      exp_q.push_back(8'hD0 + 8'(b));
      @(negedge clk); #1;
      if (b < 3) req_data[31:24] = 8'hD0 + 8'(b + 1);
      else drop_req(3);
      check("b2b_tx_byte", {24'd0, tx_byte}, {24'd0, 8'hD0 + 8'(b)});
    end
    for (int b = 1; b < 4; b++) check("b2b_spacing", t[b] - t[b-1], OCC);

    // ---- drain ----
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_exp_q", exp_q.size(), 0);
    check("no_dv_while_busy", bad_dv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
